// File: rtl/dm_cache.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dm_cache: direct-mapped, write-through, no-write-allocate cache in front of
// a 1-cycle synchronous single-port RAM, with saturating hit/miss counters.
// Revision: 1.0
// ---------------------------------------------------------------------------
module dm_cache #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 256,
  parameter int LINES     = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [$clog2(DEPTH)-1:0] req_addr,
  input  logic [WIDTH-1:0]         req_wdata,
  output logic                     resp_valid,
  output logic [WIDTH-1:0]         resp_rdata,
  output logic                     mem_we,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [WIDTH-1:0]         mem_wdata,
  input  logic [WIDTH-1:0]         mem_rdata,
  output logic [CNT_WIDTH-1:0]     hit_cnt,
  output logic [CNT_WIDTH-1:0]     miss_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(LINES);
  localparam int TW = AW - IW;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOOKUP   = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t           state;
  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [LINES-1:0] line_valid;
  logic [TW-1:0]    line_tag  [LINES];
  logic [WIDTH-1:0] line_data [LINES];

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          hit;

  assign idx = addr_q[IW-1:0];
  assign tag = addr_q[AW-1:IW];
  assign hit = line_valid[idx] && (line_tag[idx] == tag);

  // Outputs decode from state so read-miss data can pass straight from the RAM.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = 1'b0;
    resp_rdata = '0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      LOOKUP: begin
        if (we_q) begin
          resp_valid = 1'b1;
          mem_we     = 1'b1;
          mem_addr   = addr_q;
          mem_wdata  = wdata_q;
        end else if (hit) begin
          resp_valid = 1'b1;
          resp_rdata = line_data[idx];
        end else begin
          mem_addr   = addr_q;
        end
      end
      MEM_WAIT: begin
        resp_valid = 1'b1;
        resp_rdata = mem_rdata;
        mem_addr   = addr_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      line_valid <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      for (int i = 0; i < LINES; i++) begin
        line_tag[i]  <= '0;
        line_data[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + CNT_WIDTH'(1);
          end else begin
            if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + CNT_WIDTH'(1);
          end
          // Write misses are not allocated; write hits keep the line coherent.
          if (we_q) begin
            if (hit) line_data[idx] <= wdata_q;
            state <= IDLE;
          end else if (hit) begin
            state <= IDLE;
          end else begin
            state <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          line_valid[idx] <= 1'b1;
          line_tag[idx]   <= tag;
          line_data[idx]  <= mem_rdata;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_cache.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dm_cache: vector table plus scoreboard bench for dm_cache, with a second
// instance using 4-bit counters to observe saturation.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_dm_cache;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_we = 1'b0;
  logic [7:0] req_addr = '0;
  logic [7:0] req_wdata = '0;

  logic        req_ready, resp_valid, mem_we;
  logic [7:0]  resp_rdata, mem_addr, mem_wdata;
  logic [15:0] hit_cnt, miss_cnt;

  logic        req_ready4, resp_valid4, mem_we4;
  logic [7:0]  resp_rdata4, mem_addr4, mem_wdata4;
  logic [3:0]  hit_cnt4, miss_cnt4;

  logic [7:0] ram [256];
  logic [7:0] ram_q;

  always #5 clk = ~clk;

  dm_cache #(.WIDTH(8), .DEPTH(256), .LINES(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(ram_q),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  dm_cache #(.WIDTH(8), .DEPTH(256), .LINES(16), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready4),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid4), .resp_rdata(resp_rdata4), .mem_we(mem_we4),
    .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_rdata(ram_q),
    .hit_cnt(hit_cnt4), .miss_cnt(miss_cnt4)
  );

  // Single-port RAM that clears on reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
      ram_q <= '0;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      ram_q <= ram[mem_addr];
    end
  end

  typedef struct {
    logic [7:0] rdata;
    int         lat;
    int         cyc;
  } exp_t;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       exp_hit;
    logic [7:0] exp_rdata;
  } vec_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] ram_m [256];
  bit         cv [16];
  logic [3:0] ct [16];
  int         hit_m = 0;
  int         miss_m = 0;
  logic [7:0] last_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    for (int i = 0; i < 256; i++) ram_m[i] = '0;
    for (int i = 0; i < 16; i++) begin
      cv[i] = 1'b0;
      ct[i] = '0;
    end
    hit_m  = 0;
    miss_m = 0;
  endtask

  function automatic int sat4(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Reference model: predicts hit/miss, data and latency at acceptance.
  always @(posedge clk) begin : accept_model
    exp_t       e;
    logic [3:0] ix;
    logic [3:0] tg;
    bit         h;
    if (rst_n && req_valid && req_ready) begin
      ix = req_addr[3:0];
      tg = req_addr[7:4];
      h  = cv[ix] && (ct[ix] == tg);
      if (h) hit_m++; else miss_m++;
      e.cyc = cyc;
      if (req_we) begin
        ram_m[req_addr] = req_wdata;
        e.rdata = 8'h00;
        e.lat   = 1;
      end else begin
        e.rdata = ram_m[req_addr];
        e.lat   = h ? 1 : 2;
        if (!h) begin
          cv[ix] = 1'b1;
          ct[ix] = tg;
        end
      end
      sb.push_back(e);
    end
    cyc++;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      check("req_ready", {31'd0, req_ready}, {31'd0, sb.size() == 0});
      check("req_ready_c4", {31'd0, req_ready4}, {31'd0, sb.size() == 0});
      if (resp_valid || resp_valid4) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: got resp_valid=1 expected no response (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("resp_valid", {31'd0, resp_valid}, 32'd1);
          check("resp_valid_c4", {31'd0, resp_valid4}, 32'd1);
          check("resp_rdata", {24'd0, resp_rdata}, {24'd0, e.rdata});
          check("resp_rdata_c4", {24'd0, resp_rdata4}, {24'd0, e.rdata});
          check("latency", cyc - e.cyc, e.lat);
          last_rdata = resp_rdata;
        end
      end else begin
        check("idle_rdata", {24'd0, resp_rdata}, 32'd0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_resp_rdata"}, {24'd0, resp_rdata}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_addr"}, {24'd0, mem_addr}, 32'd0);
    check({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
    check({tag, "_hit_cnt"}, {16'd0, hit_cnt}, 32'd0);
    check({tag, "_miss_cnt"}, {16'd0, miss_cnt}, 32'd0);
  endtask

  task automatic do_req(input logic we, input logic [7:0] a, input logic [7:0] d,
                        output logic lk_we, output logic [7:0] lk_addr,
                        output logic [7:0] lk_wdata);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    lk_we = mem_we; lk_addr = mem_addr; lk_wdata = mem_wdata;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("resp_outstanding", sb.size(), 32'd0);
    sb.delete();
    check("hit_cnt", {16'd0, hit_cnt}, hit_m);
    check("miss_cnt", {16'd0, miss_cnt}, miss_m);
    check("hit_cnt_c4", {28'd0, hit_cnt4}, sat4(hit_m));
    check("miss_cnt_c4", {28'd0, miss_cnt4}, sat4(miss_m));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t       tbl [7];
    vec_t       held [7];
    logic       lk_we;
    logic [7:0] lk_addr, lk_wdata;
    logic [15:0] hb, mb;
    int         n;

    tbl[0] = '{1'b0, 8'h25, 8'h00, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 8'h25, 8'h00, 1'b1, 8'h00};
    tbl[2] = '{1'b1, 8'h25, 8'hA5, 1'b1, 8'h00};
    tbl[3] = '{1'b0, 8'h25, 8'h00, 1'b1, 8'hA5};
    tbl[4] = '{1'b1, 8'h15, 8'h3C, 1'b0, 8'h00};
    tbl[5] = '{1'b0, 8'h15, 8'h00, 1'b0, 8'h3C};
    tbl[6] = '{1'b0, 8'h25, 8'h00, 1'b0, 8'hA5};

    held[0] = '{1'b0, 8'h25, 8'h00, 1'b1, 8'hA5};
    held[1] = '{1'b0, 8'h15, 8'h00, 1'b0, 8'h3C};
    held[2] = '{1'b0, 8'h15, 8'h00, 1'b1, 8'h3C};
    held[3] = '{1'b1, 8'h33, 8'h77, 1'b0, 8'h00};
    held[4] = '{1'b0, 8'h33, 8'h00, 1'b0, 8'h77};
    held[5] = '{1'b0, 8'h33, 8'h00, 1'b1, 8'h77};
    held[6] = '{1'b0, 8'h25, 8'h00, 1'b0, 8'hA5};

    model_reset();
    #12;
    check_reset_outputs("rst0");
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: hit/miss, write-through and line-5 conflict.
    for (int i = 0; i < 7; i++) begin
      hb = hit_cnt;
      mb = miss_cnt;
      do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, lk_we, lk_addr, lk_wdata);
      check("vec_rdata", {24'd0, last_rdata}, {24'd0, tbl[i].exp_rdata});
      check("vec_hit_inc", {16'd0, hit_cnt - hb}, {31'd0, tbl[i].exp_hit});
      check("vec_miss_inc", {16'd0, miss_cnt - mb}, {31'd0, !tbl[i].exp_hit});
      if (!tbl[i].we && tbl[i].exp_hit) begin
        check("vec_hit_mem_we", {31'd0, lk_we}, 32'd0);
        check("vec_hit_mem_addr", {24'd0, lk_addr}, 32'd0);
      end else begin
        check("vec_mem_we", {31'd0, lk_we}, {31'd0, tbl[i].we});
        check("vec_mem_addr", {24'd0, lk_addr}, {24'd0, tbl[i].addr});
        check("vec_mem_wdata", {24'd0, lk_wdata}, tbl[i].we ? {24'd0, tbl[i].wdata} : 32'd0);
      end
    end

    // req_valid held high across hits and misses.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = held[i].we; req_addr = held[i].addr; req_wdata = held[i].wdata;
      n = 0;
      while (!req_ready && n < 10) begin
        @(negedge clk);
        n++;
      end
      if (n >= 10) check("held_accept_timeout", 32'd1, 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (4) @(posedge clk);
    #1;
    check("held_outstanding", sb.size(), 32'd0);
    check("held_rdata_last", {24'd0, last_rdata}, 32'hA5);
    check("held_hit_cnt", {16'd0, hit_cnt}, 32'd6);
    check("held_miss_cnt", {16'd0, miss_cnt}, 32'd8);

    // Reset during MEM_WAIT of a read miss on 0x15.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h15; req_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("rst_mw");
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    do_req(1'b0, 8'h15, 8'h00, lk_we, lk_addr, lk_wdata);
    check("post_rst_rdata", {24'd0, last_rdata}, 32'd0);
    check("post_rst_miss", {16'd0, miss_cnt}, 32'd1);

    // 20 read hits: the 4-bit hit counter saturates at 15.
    for (int i = 0; i < 20; i++) do_req(1'b0, 8'h15, 8'h00, lk_we, lk_addr, lk_wdata);
    check("sat_hit_c4", {28'd0, hit_cnt4}, 32'd15);
    check("sat_miss_c4", {28'd0, miss_cnt4}, 32'd1);
    check("sat_hit_c16", {16'd0, hit_cnt}, 32'd20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dm_cache.md
# dm_cache

Direct-mapped, write-through, no-write-allocate cache controller sitting directly upstream of the single-port data RAM (1-cycle synchronous read, write-enable, address, data). It accepts one CPU-side request at a time over a valid/ready handshake, serves read hits from its own line store, and forwards read misses and all writes to the RAM. It also keeps saturating hit and miss counters for the project's performance measurements.

## Interface
- WIDTH, 8, data word width; must equal the RAM's WIDTH
- DEPTH, 256, RAM depth in words; address width AW = $clog2(DEPTH)
- LINES, 16, cache lines (one word per line); power of 2, LINES < DEPTH; IW = $clog2(LINES), TW = AW - IW
- CNT_WIDTH, 16, width of the hit/miss counters

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  AW  word address
- req_wdata  in  WIDTH  write data
- resp_valid  out  1  single-cycle response pulse; no backpressure
- resp_rdata  out  WIDTH  read data; 0 when resp_valid is low or when the response is for a write
- mem_we  out  1  to RAM we
- mem_addr  out  AW  to RAM addr
- mem_wdata  out  WIDTH  to RAM data_in
- mem_rdata  in  WIDTH  from RAM data_out; valid the cycle after the address is presented
- hit_cnt  out  CNT_WIDTH  lookups that hit
- miss_cnt  out  CNT_WIDTH  lookups that missed

## Operation
- Address split: index = req_addr[IW-1:0]; tag = req_addr[AW-1:IW].
- Per line: valid bit, TW-bit tag, WIDTH-bit data. Hit = valid[index] && tag[index] == tag.
- FSM states: IDLE, LOOKUP, MEM_WAIT.
- IDLE: req_ready = 1. When req_valid is high, register we, addr and wdata, then go to LOOKUP. In all other states req_ready = 0.
- LOOKUP, read hit: resp_valid = 1, resp_rdata = line data, hit_cnt increments, go to IDLE. No RAM access.
- LOOKUP, read miss: mem_addr = registered addr, mem_we = 0, miss_cnt increments, go to MEM_WAIT.
- LOOKUP, write: mem_we = 1, mem_addr = addr, mem_wdata = wdata, resp_valid = 1, resp_rdata = 0, go to IDLE.
  - On a hit, the line data is updated to wdata in the same edge and hit_cnt increments.
  - On a miss, the line is not allocated and miss_cnt increments.
- MEM_WAIT: hold mem_addr, mem_we = 0. Fill the line with valid = 1, tag, and data = mem_rdata. Drive resp_valid = 1 and resp_rdata = mem_rdata, then go to IDLE.
- When not in an access cycle, mem_we, mem_addr and mem_wdata are 0.
- Counters saturate at 2^CNT_WIDTH - 1 and never wrap.
- Every LOOKUP counts exactly one hit or one miss.
- Reset (rst_n low, asynchronous):
  - state = IDLE; all valid bits, tags, line data and counters = 0
  - outputs: req_ready = 1, resp_valid = 0, resp_rdata = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0
  - Cache contents stay consistent with the RAM, which also clears on reset.
- Reset in LOOKUP or MEM_WAIT abandons the request: no fill, no response, no further counter change.

## Timing
- Request accepted at the edge where req_valid && req_ready.
- Read hit: resp_valid one cycle after acceptance.
- Write (hit or miss): resp_valid one cycle after acceptance; the RAM write commits at the end of that cycle.
- Read miss: resp_valid two cycles after acceptance.
- Back-to-back throughput: one request per 2 cycles (hit or write), or per 3 cycles (read miss).
- A request may be presented in the same cycle resp_valid is high; it is accepted only on the following IDLE cycle.
- A read of an address immediately after a write to it returns the new data, either from the line (hit) or from the RAM (miss, write already committed).

## Test plan
- Reset, then read 0x25: miss. mem_addr = 0x25 in LOOKUP; resp_valid with 0x00 two cycles after acceptance; miss_cnt = 1. Re-read 0x25: hit in one cycle, hit_cnt = 1, no RAM access.
- Write 0x25 ← 0xA5 (line valid): mem_we = 1, mem_addr = 0x25, mem_wdata = 0xA5 in LOOKUP; hit_cnt = 2. Read 0x25: hit, returns 0xA5.
- Conflict on line 5:
  - Write 0x15 ← 0x3C: miss, no allocate.
  - Read 0x15: miss, returns 0x3C; line 5 now holds tag 1.
  - Read 0x25: miss, returns 0xA5 from RAM.
- req_valid held high across a mix of hits and misses: req_ready low in LOOKUP and MEM_WAIT; exactly one resp_valid per accepted request; spacing 2 or 3 cycles as specified.
- Drop rst_n during MEM_WAIT of a read of 0x15: no resp_valid, outputs return to reset values. A subsequent read of 0x15 misses and returns 0x00.
- CNT_WIDTH = 4: issue 20 read hits. hit_cnt stops at 15 and does not wrap; miss_cnt is unchanged.
